// File: rtl/bcd_multimode_timer.sv
// ============================================================================
// Module   : bcd_multimode_timer
// Brief    : HH:MM:SS packed-BCD countdown / count-up timer with pause,
//            auto-reload, preset validation and a timed alarm ring.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_multimode_timer #(
    parameter int TICK_DIV    = 1000,
    parameter int MAX_HOURS   = 99,
    parameter int RING_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       ring_ack,
    input  logic       mode_up,
    input  logic       auto_reload,
    input  logic [7:0] hour_bcd_in,
    input  logic [7:0] minute_bcd_in,
    input  logic [7:0] second_bcd_in,
    output logic [7:0] hour_out_bcd,
    output logic [7:0] minute_out_bcd,
    output logic [7:0] second_out_bcd,
    output logic [1:0] state_out,
    output logic       expired,
    output logic       ring,
    output logic       load_err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
    localparam logic [PW-1:0] c_tick_last  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] c_presc_one  = PW'(1);
    localparam logic [RW-1:0] c_ring_last  = RW'((RING_CYCLES > 0) ? RING_CYCLES - 1 : 0);
    localparam logic [RW-1:0] c_ring_one   = RW'(1);
    localparam logic [7:0]    c_max_hours  = 8'(MAX_HOURS);
    localparam bit            c_ring_timed = (RING_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_RING  = 2'b11
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [23:0]     r_count, r_preset;
    logic            r_mode_up, r_auto_reload, r_reload_pend;
    logic [PW-1:0]   r_presc;
    logic [RW-1:0]   r_ring_cnt;
    logic            r_ring, r_expired, r_load_err;
    logic [7:0]      r_hour_out, r_minute_out, r_second_out;

    logic [7:0]      w_hours_bin;
    logic            w_preset_ok, w_count_en, w_tick, w_expire;
    logic            w_borrow_s, w_borrow_m, w_carry_s, w_carry_m;
    logic [23:0]     w_dn, w_up, w_step, w_count_nxt;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] tens_max);
        logic [7:0] r;
        if (v == {tens_max, 4'h9})  r = 8'h00;
        else if (v[3:0] == 4'h9)    r = {v[7:4] + 4'h1, 4'h0};
        else                        r = {v[7:4], v[3:0] + 4'h1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [3:0] tens_max);
        logic [7:0] r;
        if (v == 8'h00)             r = {tens_max, 4'h9};
        else if (v[3:0] == 4'h0)    r = {v[7:4] - 4'h1, 4'h9};
        else                        r = {v[7:4], v[3:0] - 4'h1};
        return r;
    endfunction

    always_comb begin
        w_hours_bin = {1'b0, hour_bcd_in[7:4], 3'b000} + {3'b000, hour_bcd_in[7:4], 1'b0}
                    + {4'h0, hour_bcd_in[3:0]};
        w_preset_ok = (hour_bcd_in[7:4] <= 4'd9)   && (hour_bcd_in[3:0] <= 4'd9)
                   && (minute_bcd_in[7:4] <= 4'd5) && (minute_bcd_in[3:0] <= 4'd9)
                   && (second_bcd_in[7:4] <= 4'd5) && (second_bcd_in[3:0] <= 4'd9)
                   && (w_hours_bin <= c_max_hours);

        // ring_ack outranks pause, so an ack in RUN keeps the count moving
        w_count_en = (r_state == ST_RUN) && !clear && !load && (ring_ack || !pause);
        w_tick     = w_count_en && (r_presc == c_tick_last);

        w_borrow_s = (r_count[7:0] == 8'h00);
        w_borrow_m = w_borrow_s && (r_count[15:8] == 8'h00);
        w_dn = {w_borrow_m ? bcd_dec(r_count[23:16], 4'h9) : r_count[23:16],
                w_borrow_s ? bcd_dec(r_count[15:8], 4'h5)  : r_count[15:8],
                bcd_dec(r_count[7:0], 4'h5)};
        if (r_count == 24'h0)
            w_dn = 24'h0;

        w_carry_s = (r_count[7:0] == 8'h59);
        w_carry_m = w_carry_s && (r_count[15:8] == 8'h59);
        w_up = {w_carry_m ? bcd_inc(r_count[23:16], 4'h9) : r_count[23:16],
                w_carry_s ? bcd_inc(r_count[15:8], 4'h5)  : r_count[15:8],
                bcd_inc(r_count[7:0], 4'h5)};

        w_step      = r_mode_up ? w_up : w_dn;
        w_count_nxt = r_reload_pend ? (r_mode_up ? 24'h0 : r_preset) : w_step;
        w_expire    = w_tick && !r_reload_pend
                   && (r_mode_up ? (w_step == r_preset) : (w_step == 24'h0));
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else if (load) begin
            if (w_preset_ok)
                w_state_nxt = ST_IDLE;
        end else if (w_expire && !r_auto_reload) begin
            w_state_nxt = ST_RING;
        end else if (ring_ack) begin
            if (r_state == ST_RING)
                w_state_nxt = ST_IDLE;
        end else if (pause) begin
            if (r_state == ST_RUN)
                w_state_nxt = ST_PAUSE;
        end else if (start) begin
            if ((r_state == ST_IDLE && r_preset != 24'h0) || r_state == ST_PAUSE)
                w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count       <= 24'h0;
            r_preset      <= 24'h0;
            r_mode_up     <= 1'b0;
            r_auto_reload <= 1'b0;
            r_reload_pend <= 1'b0;
            r_presc       <= '0;
            r_ring_cnt    <= '0;
            r_ring        <= 1'b0;
            r_expired     <= 1'b0;
            r_load_err    <= 1'b0;
            r_hour_out    <= 8'h00;
            r_minute_out  <= 8'h00;
            r_second_out  <= 8'h00;
        end else begin
            r_expired    <= 1'b0;
            r_load_err   <= 1'b0;
            r_hour_out   <= r_count[23:16];
            r_minute_out <= r_count[15:8];
            r_second_out <= r_count[7:0];
            if (clear) begin
                r_count       <= 24'h0;
                r_preset      <= 24'h0;
                r_mode_up     <= 1'b0;
                r_auto_reload <= 1'b0;
                r_reload_pend <= 1'b0;
                r_presc       <= '0;
                r_ring_cnt    <= '0;
                r_ring        <= 1'b0;
            end else if (load) begin
                if (w_preset_ok) begin
                    r_preset      <= {hour_bcd_in, minute_bcd_in, second_bcd_in};
                    r_count       <= mode_up ? 24'h0 : {hour_bcd_in, minute_bcd_in, second_bcd_in};
                    r_mode_up     <= mode_up;
                    r_auto_reload <= auto_reload;
                    r_reload_pend <= 1'b0;
                    r_presc       <= '0;
                    r_ring_cnt    <= '0;
                    r_ring        <= 1'b0;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else begin
                if (r_state == ST_IDLE && w_state_nxt == ST_RUN)
                    r_presc <= '0;
                if (w_count_en) begin
                    r_presc <= w_tick ? '0 : r_presc + c_presc_one;
                    if (w_tick) begin
                        r_count       <= w_count_nxt;
                        r_reload_pend <= w_expire && r_auto_reload;
                    end
                end
                if (w_expire) begin
                    r_expired  <= 1'b1;
                    r_ring     <= 1'b1;
                    r_ring_cnt <= '0;
                end else if (ring_ack) begin
                    r_ring <= 1'b0;
                end else if (c_ring_timed && r_ring) begin
                    if (r_ring_cnt == c_ring_last)
                        r_ring <= 1'b0;
                    else
                        r_ring_cnt <= r_ring_cnt + c_ring_one;
                end
            end
        end
    end

    assign hour_out_bcd   = r_hour_out;
    assign minute_out_bcd = r_minute_out;
    assign second_out_bcd = r_second_out;
    assign state_out      = r_state;
    assign expired        = r_expired;
    assign ring           = r_ring;
    assign load_err       = r_load_err;

endmodule

`default_nettype wire
